// File: rtl/ifm_window_fetch.sv
// rtl/ifm_window_fetch.sv - KxK window read sequencer for the IFM BRAM with a 2-entry output FIFO
module ifm_window_fetch #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DIM_W-1:0]  cfg_cwords,
    input  logic [1:0]        cfg_kernel,
    input  logic [1:0]        cfg_stride,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last_win,
    output logic              out_last
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

    state_t state_q, state_n;

    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  w_q, h_q, cw_q;
    logic [1:0]        k_q, s_q;

    logic [DIM_W-1:0]  c_q, ox_q, oy_q;
    logic [1:0]        kx_q, ky_q;
    logic [DIM_W-1:0]  c_n, ox_n, oy_n;
    logic [1:0]        kx_n, ky_n;

    logic [ADDR_W-1:0] rd_addr_q, addr_n;

    logic              infl_q, infl_lw_q, infl_l_q;

    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_lw, fifo_l;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_n;

    logic              cfg_bad, start_ok;
    logic [DIM_W-1:0]  cw_m1, ow_m1, oh_m1, diff_w, diff_h;
    logic [1:0]        k_m1;
    logic              last_c, last_kx, last_ky, last_ox, last_oy;
    logic              win_end, job_end;
    logic              issue, fifo_empty, accept, push, pop_fifo;
    logic [ADDR_W-1:0] row, col, pix, off;

    // S=3 cannot be derived with a shift, so it is rejected together with the other illegal configs
    assign cfg_bad = (cfg_width == '0) || (cfg_height == '0) || (cfg_cwords == '0) ||
                     (cfg_kernel == 2'd0) || (cfg_stride == 2'd0) || (cfg_stride == 2'd3) ||
                     (DIM_W'(cfg_kernel) > cfg_width) || (DIM_W'(cfg_kernel) > cfg_height);
    assign start_ok = (state_q == S_IDLE) && start;

    assign k_m1   = k_q - 2'd1;
    assign cw_m1  = cw_q - 1'b1;
    assign diff_w = w_q - DIM_W'(k_q);
    assign diff_h = h_q - DIM_W'(k_q);
    assign ow_m1  = s_q[1] ? (diff_w >> 1) : diff_w;
    assign oh_m1  = s_q[1] ? (diff_h >> 1) : diff_h;

    assign last_c  = (c_q == cw_m1);
    assign last_kx = (kx_q == k_m1);
    assign last_ky = (ky_q == k_m1);
    assign last_ox = (ox_q == ow_m1);
    assign last_oy = (oy_q == oh_m1);
    assign win_end = last_c && last_kx && last_ky;
    assign job_end = win_end && last_ox && last_oy;

    assign issue      = (state_q == S_RUN) && ((3'(cnt_q) + 3'(infl_q)) < 3'd2);
    assign fifo_empty = (cnt_q == 2'd0);

    // An empty FIFO is bypassed so a word returning from BRAM can leave in the same cycle
    assign out_valid    = !fifo_empty || infl_q;
    assign out_data     = !fifo_empty ? fifo_data[rd_ptr_q] : (infl_q ? bram_data : '0);
    assign out_last_win = !fifo_empty ? fifo_lw[rd_ptr_q]   : (infl_q && infl_lw_q);
    assign out_last     = !fifo_empty ? fifo_l[rd_ptr_q]    : (infl_q && infl_l_q);

    assign accept   = out_valid && out_ready;
    assign pop_fifo = !fifo_empty && accept;
    assign push     = infl_q && !(fifo_empty && accept);
    assign cnt_n    = cnt_q + {1'b0, push} - {1'b0, pop_fifo};

    assign rd_addr = rd_addr_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE) || (state_q == S_ERR);
    assign cfg_err = (state_q == S_ERR);

    // Loop nest, outermost first: oy, ox, ky, kx, c
    always_comb begin
        c_n  = c_q;
        kx_n = kx_q;
        ky_n = ky_q;
        ox_n = ox_q;
        oy_n = oy_q;
        if (!last_c) begin
            c_n = c_q + 1'b1;
        end else begin
            c_n = '0;
            if (!last_kx) begin
                kx_n = kx_q + 2'd1;
            end else begin
                kx_n = '0;
                if (!last_ky) begin
                    ky_n = ky_q + 2'd1;
                end else begin
                    ky_n = '0;
                    if (!last_ox) begin
                        ox_n = ox_q + 1'b1;
                    end else begin
                        ox_n = '0;
                        oy_n = oy_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        row    = ADDR_W'(oy_n) * ADDR_W'(s_q) + ADDR_W'(ky_n);
        col    = ADDR_W'(ox_n) * ADDR_W'(s_q) + ADDR_W'(kx_n);
        pix    = row * ADDR_W'(w_q) + col;
        off    = pix * ADDR_W'(cw_q) + ADDR_W'(c_n);
        addr_n = base_q + (off << 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (start) state_n = cfg_bad ? S_ERR : S_RUN;
            S_RUN:   if (issue && job_end) state_n = S_DRAIN;
            S_DRAIN: if (cnt_n == 2'd0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            w_q       <= '0;
            h_q       <= '0;
            cw_q      <= '0;
            k_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            rd_addr_q <= '0;
            infl_q    <= 1'b0;
            infl_lw_q <= 1'b0;
            infl_l_q  <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_lw_q <= win_end;
                infl_l_q  <= job_end;
            end
            if (start_ok) begin
                base_q    <= cfg_base_addr;
                w_q       <= cfg_width;
                h_q       <= cfg_height;
                cw_q      <= cfg_cwords;
                k_q       <= cfg_kernel;
                s_q       <= cfg_stride;
                c_q       <= '0;
                kx_q      <= '0;
                ky_q      <= '0;
                ox_q      <= '0;
                oy_q      <= '0;
                rd_addr_q <= cfg_base_addr;
            end else if (issue) begin
                c_q  <= c_n;
                kx_q <= kx_n;
                ky_q <= ky_n;
                ox_q <= ox_n;
                oy_q <= oy_n;
                if (!job_end) begin
                    rd_addr_q <= addr_n;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_lw      <= '0;
            fifo_l       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= bram_data;
                fifo_lw[wr_ptr_q]   <= infl_lw_q;
                fifo_l[wr_ptr_q]    <= infl_l_q;
                wr_ptr_q            <= !wr_ptr_q;
            end
            if (pop_fifo) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            cnt_q <= cnt_n;
        end
    end

endmodule

// File: tb/tb_ifm_window_fetch.sv
// tb/tb_ifm_window_fetch.sv - scoreboard bench for ifm_window_fetch
module tb_ifm_window_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] cfg_base_addr = '0;
    logic [7:0]  cfg_width = '0, cfg_height = '0, cfg_cwords = '0;
    logic [1:0]  cfg_kernel = '0, cfg_stride = '0;
    logic [19:0] rd_addr;
    logic [31:0] bram_data = '0;
    logic        busy, done, cfg_err;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last_win, out_last;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] sb[$];
    logic [31:0] mem [0:1023];
    logic [31:0] log_d [0:127];
    int          pop_cnt = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          ready_mode = 1'b0;
    int          phase = 0;
    logic [3:0]  pat = 4'b1001;
    logic [31:0] win0 [0:8];

    ifm_window_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_cwords(cfg_cwords), .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
        .rd_addr(rd_addr), .bram_data(bram_data),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last_win(out_last_win), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bram_data <= mem[rd_addr[11:2]];
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            out_ready = ready_mode ? pat[phase] : 1'b1;
            phase = (phase + 1) % 4;
            if (out_valid && out_ready) begin
                logic [33:0] e;
                chk("unexpected_word", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e[31:0]));
                    chk("out_last_win", 64'(out_last_win), 64'(e[32]));
                    chk("out_last", 64'(out_last), 64'(e[33]));
                end
                if (pop_cnt < 128) log_d[pop_cnt] = out_data;
                if (out_last) last_cyc = cyc;
                pop_cnt++;
            end
        end
    end

    task automatic push_job(input int base, input int w, input int h, input int cw,
                            input int k, input int s);
        int ow, oh;
        logic [19:0] a;
        logic lw, l;
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        for (int c = 0; c < cw; c++) begin
                            a  = 20'(base + ((((oy * s + ky) * w + ox * s + kx) * cw + c) * 4));
                            lw = (kx == k - 1) && (ky == k - 1) && (c == cw - 1);
                            l  = lw && (ox == ow - 1) && (oy == oh - 1);
                            sb.push_back({l, lw, mem[a[11:2]]});
                        end
    endtask

    task automatic start_job(input int base, input int w, input int h, input int cw,
                             input int k, input int s);
        pop_cnt = 0;
        push_job(base, w, h, cw, k, s);
        @(negedge clk);
        cfg_base_addr = 20'(base);
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_cwords = 8'(cw);
        cfg_kernel = 2'(k); cfg_stride = 2'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_base_addr = 20'hABCDE; cfg_width = 8'hFF; cfg_height = 8'hFF;
        cfg_cwords = 8'hFF; cfg_kernel = 2'd1; cfg_stride = 2'd1;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int dcyc;
        bit hit;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hBEEF0000 | 32'(i);
        win0[0] = 32'hBEEF0000; win0[1] = 32'hBEEF0001; win0[2] = 32'hBEEF0002;
        win0[3] = 32'hBEEF0004; win0[4] = 32'hBEEF0005; win0[5] = 32'hBEEF0006;
        win0[6] = 32'hBEEF0008; win0[7] = 32'hBEEF0009; win0[8] = 32'hBEEF000A;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({rd_addr, busy, done, cfg_err, out_valid, out_last_win, out_last, out_data}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: 4x4, K=3, S=1, ready held high
        ready_mode = 1'b0;
        start_job(0, 4, 4, 1, 3, 1);
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_valid_early", 64'(out_valid), 64'd0);
        chk("s1_first_addr", 64'(rd_addr), 64'd0);
        @(negedge clk);
        chk("s1_latency", 64'(out_valid), 64'd1);
        wait_done("s1", dcyc);
        chk("s1_done_timing", 64'(dcyc), 64'(last_cyc + 1));
        chk("s1_count", 64'(pop_cnt), 64'd36);
        chk("s1_sb_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 9; i++) chk("s1_win0_addr", 64'(log_d[i]), 64'(win0[i]));
        chk("s1_win1_first", 64'(log_d[9]), 64'h0000_0000_BEEF_0001);
        @(negedge clk);
        chk("s1_done_pulse", 64'({done, busy}), 64'd0);

        // Scenario 2: 5x5, CW=2, K=3, S=2, base 0x100
        start_job(32'h100, 5, 5, 2, 3, 2);
        chk("s2_first_addr", 64'(rd_addr), 64'h100);
        wait_done("s2", dcyc);
        chk("s2_count", 64'(pop_cnt), 64'd72);
        chk("s2_sb_empty", 64'(sb.size()), 64'd0);
        chk("s2_win1_first", 64'(log_d[18]), 64'h0000_0000_BEEF_0044);

        // Scenario 3: backpressure 1,0,0,1 plus an ignored start mid-job
        ready_mode = 1'b1;
        phase = 0;
        start_job(0, 4, 4, 1, 3, 1);
        repeat (15) @(negedge clk);
        cfg_width = 8'd8; cfg_height = 8'd8; cfg_kernel = 2'd1; cfg_base_addr = 20'h200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("s3", dcyc);
        chk("s3_count", 64'(pop_cnt), 64'd36);
        chk("s3_sb_empty", 64'(sb.size()), 64'd0);
        ready_mode = 1'b0;

        // Illegal config: K=3 > W=2
        pop_cnt = 0;
        @(negedge clk);
        cfg_width = 8'd2; cfg_height = 8'd4; cfg_cwords = 8'd1;
        cfg_kernel = 2'd3; cfg_stride = 2'd1; cfg_base_addr = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 64'({cfg_err, done, busy, out_valid}), 64'b1100);
        @(negedge clk);
        chk("err_clear", 64'({cfg_err, done, busy, out_valid}), 64'b0000);
        chk("err_no_words", 64'(pop_cnt), 64'd0);

        // Reset at word 10, then a full rerun
        start_job(0, 4, 4, 1, 3, 1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (pop_cnt >= 10) hit = 1'b1;
        end
        chk("rst_reach_word10", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 64'({rd_addr, busy, done, cfg_err, out_valid, out_last_win, out_last, out_data}), 64'd0);
        sb.delete();
        @(negedge clk);
        chk("rst_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(0, 4, 4, 1, 3, 1);
        wait_done("rerun", dcyc);
        chk("rerun_count", 64'(pop_cnt), 64'd36);
        chk("rerun_sb_empty", 64'(sb.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
